// File: rtl/time_set_ctrl.sv
// -----------------------------------------------------------------------------
// time_set_ctrl
//   Owns the HH:MM:SS wall-clock registers. The 1 Hz tick advances them, and the
//   debounced hour and minute set buttons are turned into increment commands.
//   A press gives one increment. Holding the button then gives auto-repeat
//   increments. The hour button has fixed priority over the minute button.
//
// Configuration macro:
//   TIME_SET_AUTO_REPEAT_EN  defined   -> hold-to-auto-repeat is enabled
//                            undefined -> one increment per press only
//
// Parameters:
//   HOLD_CYCLES    cycles a button stays held before auto-repeat starts
//   REPEAT_CYCLES  cycles between auto-repeat increments
//   CNT_W          width of the hold/repeat counter
//
// Ports:
//   Clk_100M    in   system clock
//   Reset       in   synchronous active-high reset
//   hour_btn    in   debounced hour-set level
//   min_btn     in   debounced minute-set level
//   sec_tick    in   one-cycle 1 Hz pulse
//   hours       out  0..23, registered
//   minutes     out  0..59, registered
//   seconds     out  0..59, registered
//   set_active  out  high while a set button owns the controller, registered
// -----------------------------------------------------------------------------
module time_set_ctrl #(
   parameter int unsigned HOLD_CYCLES   = 50_000_000,
   parameter int unsigned REPEAT_CYCLES = 20_000_000,
   parameter int unsigned CNT_W         = 26
) (
   input  logic       Clk_100M,
   input  logic       Reset,
   input  logic       hour_btn,
   input  logic       min_btn,
   input  logic       sec_tick,
   output logic [4:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic       set_active
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_HOUR_HELD = 2'd1;
   localparam logic [1:0] ST_MIN_HELD  = 2'd2;

   // Reject parameter sets the counter cannot represent.
   if ((CNT_W < $clog2(HOLD_CYCLES)) || (REPEAT_CYCLES == 32'd0) ||
       (REPEAT_CYCLES >= HOLD_CYCLES)) begin : g_bad_params
      $error("time_set_ctrl: inconsistent HOLD_CYCLES/REPEAT_CYCLES/CNT_W");
   end

   // Hour increment with 23 -> 0 wrap.
   function automatic logic [4:0] inc_hour(input logic [4:0] h);
      return (h == 5'd23) ? 5'd0 : h + 5'd1;
   endfunction

   // Minute/second increment with 59 -> 0 wrap.
   function automatic logic [5:0] inc_sixty(input logic [5:0] v);
      return (v == 6'd59) ? 6'd0 : v + 6'd1;
   endfunction

   logic [1:0] state_r;
   logic [1:0] state_s;
   logic [4:0] hours_s;
   logic [5:0] minutes_s;
   logic [5:0] seconds_s;
   logic       hour_prev_r;
   logic       min_prev_r;
   // An armed bit is set once its button has been seen low. A button that is
   // still held through reset therefore needs a fresh press.
   logic       hour_armed_r;
   logic       min_armed_r;
   logic       hour_rise_s;
   logic       min_rise_s;

   assign hour_rise_s = hour_btn & ~hour_prev_r & hour_armed_r;
   assign min_rise_s  = min_btn  & ~min_prev_r  & min_armed_r;

`ifdef TIME_SET_AUTO_REPEAT_EN
   // The counter holds the number of cycles held, with the press cycle as 1.
   // A repeat fires when the counter reaches HOLD_CYCLES-1. It then reloads so
   // that the next repeat fires REPEAT_CYCLES later.
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - REPEAT_CYCLES);

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             repeat_hit_s;

   assign repeat_hit_s = (cnt_r == CNT_LAST);
`endif

   // Next-state and next-time computation. Priority: release, then set, then tick.
   always_comb begin
      state_s   = state_r;
      hours_s   = hours;
      minutes_s = minutes;
      seconds_s = seconds;
`ifdef TIME_SET_AUTO_REPEAT_EN
      cnt_s     = cnt_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (hour_rise_s) begin
               // Hour wins a simultaneous rise. A coincident tick is dropped.
               state_s = ST_HOUR_HELD;
               hours_s = inc_hour(hours);
`ifdef TIME_SET_AUTO_REPEAT_EN
               cnt_s   = CNT_ONE;
`endif
            end else if (min_rise_s && !hour_btn) begin
               state_s   = ST_MIN_HELD;
               minutes_s = inc_sixty(minutes);
               seconds_s = 6'd0;
`ifdef TIME_SET_AUTO_REPEAT_EN
               cnt_s     = CNT_ONE;
`endif
            end else if (sec_tick) begin
               seconds_s = inc_sixty(seconds);
               if (seconds == 6'd59) begin
                  minutes_s = inc_sixty(minutes);
                  if (minutes == 6'd59) begin
                     hours_s = inc_hour(hours);
                  end else begin
                     hours_s = hours;
                  end
               end else begin
                  minutes_s = minutes;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_HOUR_HELD: begin
            if (!hour_btn) begin
               state_s = ST_IDLE;
`ifdef TIME_SET_AUTO_REPEAT_EN
            end else if (repeat_hit_s) begin
               hours_s = inc_hour(hours);
               cnt_s   = CNT_RELOAD;
            end else begin
               cnt_s   = cnt_r + CNT_ONE;
`else
            end else begin
               state_s = ST_HOUR_HELD;
`endif
            end
         end
         ST_MIN_HELD: begin
            if (!min_btn) begin
               state_s = ST_IDLE;
`ifdef TIME_SET_AUTO_REPEAT_EN
            end else if (repeat_hit_s) begin
               minutes_s = inc_sixty(minutes);
               seconds_s = 6'd0;
               cnt_s     = CNT_RELOAD;
            end else begin
               cnt_s     = cnt_r + CNT_ONE;
`else
            end else begin
               state_s = ST_MIN_HELD;
`endif
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State, time, button-history and output registers.
   always_ff @(posedge Clk_100M) begin
      if (Reset) begin
         state_r      <= ST_IDLE;
         hours        <= 5'd0;
         minutes      <= 6'd0;
         seconds      <= 6'd0;
         set_active   <= 1'b0;
         hour_prev_r  <= 1'b0;
         min_prev_r   <= 1'b0;
         hour_armed_r <= 1'b0;
         min_armed_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         hours        <= hours_s;
         minutes      <= minutes_s;
         seconds      <= seconds_s;
         set_active   <= (state_s != ST_IDLE);
         // History updates every cycle. A rise of the locked-out button is
         // absorbed here and is not replayed after the owner releases.
         hour_prev_r  <= hour_btn;
         min_prev_r   <= min_btn;
         hour_armed_r <= hour_armed_r | ~hour_btn;
         min_armed_r  <= min_armed_r | ~min_btn;
      end
   end

`ifdef TIME_SET_AUTO_REPEAT_EN
   // Hold/repeat counter.
   always_ff @(posedge Clk_100M) begin
      if (Reset) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_s;
      end
   end
`endif

endmodule

// File: tb/tb_time_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_time_set_ctrl
//   Directed self-checking bench for time_set_ctrl. It uses HOLD_CYCLES=10 and
//   REPEAT_CYCLES=4. Auto-repeat expectations follow TIME_SET_AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_time_set_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       hour_btn = 1'b0;
   logic       min_btn = 1'b0;
   logic       sec_tick = 1'b0;
   logic [4:0] hours;
   logic [5:0] minutes;
   logic [5:0] seconds;
   logic       set_active;

   int n_checks = 0;
   int n_fail   = 0;

   time_set_ctrl #(
      .HOLD_CYCLES  (10),
      .REPEAT_CYCLES(4),
      .CNT_W        (26)
   ) dut (
      .Clk_100M  (clk),
      .Reset     (rst),
      .hour_btn  (hour_btn),
      .min_btn   (min_btn),
      .sec_tick  (sec_tick),
      .hours     (hours),
      .minutes   (minutes),
      .seconds   (seconds),
      .set_active(set_active)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_time(input string tag, input int eh, input int em, input int es);
      n_checks++;
      assert ({hours, minutes, seconds} === {5'(eh), 6'(em), 6'(es)}) else begin
         n_fail++;
         $error("FAIL %s: observed %0d:%0d:%0d expected %0d:%0d:%0d",
                tag, hours, minutes, seconds, eh, em, es);
      end
   endtask

   task automatic chk_act(input string tag, input logic exp);
      n_checks++;
      assert (set_active === exp) else begin
         n_fail++;
         $error("FAIL %s: set_active observed %0b expected %0b", tag, set_active, exp);
      end
   endtask

   task automatic press_hour(input int n);
      for (int i = 0; i < n; i++) begin
         hour_btn = 1'b1; cyc();
         hour_btn = 1'b0; cyc();
      end
   endtask

   task automatic press_min(input int n);
      for (int i = 0; i < n; i++) begin
         min_btn = 1'b1; cyc();
         min_btn = 1'b0; cyc();
      end
   endtask

   task automatic ticks(input int n);
      sec_tick = 1'b1;
      repeat (n) cyc();
      sec_tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc();
      rst = 1'b0; cyc();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int rpt [5];
      int k;
      rpt = '{1, 10, 14, 18, 22};

      // Reset state
      cyc(); cyc();
      rst = 1'b0;
      chk_time("reset_time", 0, 0, 0);
      chk_act("reset_act", 1'b0);
      cyc();

      // 1: a full day of ticks
      ticks(59);    chk_time("tick_59", 0, 0, 59);
      ticks(1);     chk_time("tick_min_carry", 0, 1, 0);
      ticks(3540);  chk_time("tick_hour_carry", 1, 0, 0);
      ticks(82799); chk_time("tick_235959", 23, 59, 59);
      chk_act("tick_idle_act", 1'b0);
      ticks(1);     chk_time("tick_day_wrap", 0, 0, 0);

      // 2: hour held 3 cycles at 23:00:00
      press_hour(23); chk_time("set_23h", 23, 0, 0);
      hour_btn = 1'b1;
      cyc(); chk_time("hour_wrap", 0, 0, 0); chk_act("hold_act1", 1'b1);
      cyc(); chk_act("hold_act2", 1'b1);
      cyc(); chk_act("hold_act3", 1'b1); chk_time("hour_single", 0, 0, 0);
      hour_btn = 1'b0;
      cyc(); chk_act("release_act", 1'b0); chk_time("after_release", 0, 0, 0);

      // 3: minute held 22 cycles from 10:58:30
      press_hour(10); press_min(58); ticks(30);
      chk_time("pre_s3", 10, 58, 30);
      min_btn = 1'b1;
      k = 0;
      for (int c = 1; c <= 22; c++) begin
         cyc();
`ifdef TIME_SET_AUTO_REPEAT_EN
         if (k < 5 && c == rpt[k]) k++;
`else
         k = 1;
`endif
         chk_time($sformatf("min_hold_c%0d", c), 10, (58 + k) % 60, 0);
      end
      chk_act("min_hold_act", 1'b1);
      min_btn = 1'b0;
      cyc(); chk_act("min_release_act", 1'b0);
`ifdef TIME_SET_AUTO_REPEAT_EN
      chk_time("s3_final", 10, 3, 0);
`else
      chk_time("s3_final", 10, 59, 0);
`endif

      // 4: simultaneous rise from 05:05:05
      do_reset(); chk_time("s4_reset", 0, 0, 0);
      press_hour(5); press_min(5); ticks(5);
      chk_time("pre_s4", 5, 5, 5);
      hour_btn = 1'b1; min_btn = 1'b1;
      cyc(); chk_time("both_rise", 6, 5, 5); chk_act("both_act", 1'b1);
      cyc(); cyc();
      hour_btn = 1'b0;
      cyc(); chk_act("hour_rel_act", 1'b0);
      cyc(); cyc(); chk_time("min_lockout", 6, 5, 5);
      min_btn = 1'b0; cyc();
      min_btn = 1'b1; cyc(); chk_time("min_repress", 6, 6, 0);
      min_btn = 1'b0; cyc();
      hour_btn = 1'b1; cyc(); chk_time("hour_again", 7, 6, 0);
      min_btn = 1'b1; cyc(); cyc();
      hour_btn = 1'b0; cyc(); cyc();
      chk_time("late_min_lockout", 7, 6, 0); chk_act("late_min_act", 1'b0);
      min_btn = 1'b0; cyc();

      // 5: tick coincident with hour rise at 01:02:59
      do_reset();
      press_hour(1); press_min(2); ticks(59);
      chk_time("pre_s5", 1, 2, 59);
      hour_btn = 1'b1; sec_tick = 1'b1;
      cyc(); chk_time("tick_dropped", 2, 2, 59);
      cyc(); cyc(); chk_time("tick_in_held", 2, 2, 59);
      sec_tick = 1'b0; hour_btn = 1'b0; cyc();
      ticks(1); chk_time("tick_after_rel", 2, 3, 0);

      // 6: reset during a hold
      min_btn = 1'b1;
      cyc(); chk_time("s6_press", 2, 4, 0);
      repeat (6) cyc();
      rst = 1'b1;
      cyc(); chk_time("s6_reset", 0, 0, 0); chk_act("s6_reset_act", 1'b0);
      rst = 1'b0;
      repeat (3) cyc();
      chk_time("s6_still_high", 0, 0, 0); chk_act("s6_still_act", 1'b0);
      min_btn = 1'b0; cyc();
      min_btn = 1'b1; cyc(); chk_time("s6_fresh", 0, 1, 0); chk_act("s6_fresh_act", 1'b1);
      min_btn = 1'b0; cyc(); chk_act("s6_idle", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
